// File: rtl/mem_req_ctrl_if.sv
// mem_req_ctrl_if
// Data-side SRAM-like bus between the memory-stage request controller and
// the data memory. Allows one outstanding transaction.
//   master : controller side (drives req/wr/size/addr/wdata/wstrb)
//   slave  : memory side (drives addr_ok/data_ok/rdata)
interface mem_req_ctrl_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl
// Sequences the memory stage's single load/store onto the data-side bus
// (req / addr_ok / data_ok), stalls the pipeline until the access completes,
// holds load data until the pipeline advances, and cancels or drains the
// access when the exception unit flushes (kill).
//
// Optional build macro: MEM_REQ_TIMEOUT_EN adds a watchdog that abandons a
// stuck transaction after TIMEOUT_CYCLES cycles and raises sticky bus_timeout.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   d_en                2'b01 load, 2'b10 store, others no request
//   d_addr/d_wdata      byte address / lane-aligned store data
//   d_size              0 byte, 1 half, 2 word
//   w_byte_select       store byte strobes
//   kill                flush from the exception unit
//   pipe_advance        memory stage advances this cycle
//   mem_stall           freeze the pipeline (combinational)
//   d_rdata             load data returned to the memory stage
//   bus                 data-side bus (master modport), all outputs registered
//   bus_timeout         sticky watchdog flag (0 without the optional feature)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no access in flight; sample request
// S_ADDR  | data_req high, waiting for addr_ok
// S_DATA  | address accepted, waiting for data_ok
// S_DONE  | access complete, d_rdata held until pipe_advance/kill
// S_DRAIN | flushed after address accepted; discard the pending data_ok
module mem_req_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            d_en,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [2:0]            d_size,
  input  logic [3:0]            w_byte_select,
  input  logic                  kill,
  input  logic                  pipe_advance,
  output logic                  mem_stall,
  output logic [31:0]           d_rdata,
  mem_req_ctrl_if.master        bus,
  output logic                  bus_timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_req,   w_req_nxt;
  logic        r_wr,    w_wr_nxt;
  logic [1:0]  r_size,  w_size_nxt;
  logic [31:0] r_addr,  w_addr_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic [3:0]  r_wstrb, w_wstrb_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;

  logic w_req_v;
  logic w_is_store;
  // d_size[2] carries no information for the supported sizes.
  logic w_unused_size;

  assign w_is_store    = (d_en == 2'b10);
  assign w_req_v       = ((d_en == 2'b01) || w_is_store) && !kill;
  assign w_unused_size = d_size[2];

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  // Counter value in the last cycle before the limit is reached.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             w_busy;

  assign w_busy      = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_DRAIN);
  assign bus_timeout = r_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT_CYCLES;
  assign bus_timeout      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_wr    <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_wstrb <= 4'h0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_wr    <= w_wr_nxt;
      r_size  <= w_size_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_wstrb <= w_wstrb_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

`ifdef MEM_REQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_wr_nxt    = r_wr;
    w_size_nxt  = r_size;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_wstrb_nxt = r_wstrb;
    w_rdata_nxt = r_rdata;
`ifdef MEM_REQ_TIMEOUT_EN
    w_cnt_nxt     = w_busy ? (r_cnt + 1'b1) : r_cnt;
    w_timeout_nxt = r_timeout;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_req_v) begin
          w_addr_nxt  = d_addr;
          w_wdata_nxt = d_wdata;
          w_size_nxt  = d_size[1:0];
          w_wr_nxt    = w_is_store;
          w_wstrb_nxt = w_is_store ? w_byte_select : 4'b0000;
          w_req_nxt   = 1'b1;
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.data_addr_ok) begin
          w_req_nxt = 1'b0;
          if (bus.data_data_ok) begin
            if (kill) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_DONE;
              if (!r_wr) w_rdata_nxt = bus.data_rdata;
            end
          end else begin
            w_state_nxt = kill ? S_DRAIN : S_DATA;
          end
        end else if (kill) begin
          // Withdrawn before acceptance: no bus transaction took place.
          w_req_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (bus.data_data_ok) begin
          if (kill) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DONE;
            if (!r_wr) w_rdata_nxt = bus.data_rdata;
          end
        end else if (kill) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.data_data_ok) w_state_nxt = S_IDLE;
      end
      S_DONE: begin
        if (pipe_advance || kill) w_state_nxt = S_IDLE;
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase

`ifdef MEM_REQ_TIMEOUT_EN
    // Watchdog only overrides a state that would otherwise keep waiting.
    if (w_busy && (r_cnt == TO_LAST) && (w_state_nxt == r_state)) begin
      w_timeout_nxt = 1'b1;
      w_req_nxt     = 1'b0;
      if (r_state == S_DATA) begin
        w_rdata_nxt = 32'hFFFF_FFFF;
        w_state_nxt = S_DONE;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
    if (((w_state_nxt == S_ADDR) || (w_state_nxt == S_DATA)) && (w_state_nxt != r_state))
      w_cnt_nxt = '0;
`endif
  end

  assign mem_stall = ((r_state == S_IDLE) && w_req_v) ||
                     (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_DRAIN);

  assign d_rdata        = r_rdata;
  assign bus.data_req   = r_req;
  assign bus.data_wr    = r_wr;
  assign bus.data_size  = r_size;
  assign bus.data_addr  = r_addr;
  assign bus.data_wdata = r_wdata;
  assign bus.data_wstrb = r_wstrb;

endmodule
